// File: rtl/mult_datapath.sv
// Register datapath for a shift-add multiplier. The control FSM steers the
// operand A (shifts left), operand B (shifts right) and the product
// accumulator P one step per clock. This block returns B status to the FSM and
// presents P as the product.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               reset,     // synchronous, active-low
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               a_enable,
  input  logic               a_L,
  input  logic               b_enable,
  input  logic               b_L,
  input  logic               p_L,
  input  logic               Psel,
  output logic               b_lsb,
  output logic               b_zero,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [2*WIDTH-1:0] p_reg, p_next;

  // A next state: load the zero-extended multiplicand, or shift left by one.
  // a_L is only examined when a_enable is high, so an unknown a_L is harmless.
  always_comb begin
    a_next = a_reg;
    if (a_enable) begin
      if (a_L) a_next = {{WIDTH{1'b0}}, a_in};
      else     a_next = {a_reg[2*WIDTH-2:0], 1'b0};
    end
  end

  // B next state: load the multiplier, or logical shift right by one.
  always_comb begin
    b_next = b_reg;
    if (b_enable) begin
      if (b_L) b_next = b_in;
      else     b_next = {1'b0, b_reg[WIDTH-1:1]};
    end
  end

  // P next state: an operand load always clears the product, ahead of any
  // accumulate request. The add uses A as it stands before this edge.
  always_comb begin
    p_next = p_reg;
    if (a_enable && a_L) begin
      p_next = '0;
    end else if (p_L) begin
      if (Psel) p_next = p_reg + a_reg;
      else      p_next = '0;
    end
  end

  // State registers; an active-low reset clears everything and overrides controls.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      a_reg <= '0;
      b_reg <= '0;
      p_reg <= '0;
    end else begin
      a_reg <= a_next;
      b_reg <= b_next;
      p_reg <= p_next;
    end
  end

  // Status and product come straight from registers: no input-to-output path.
  assign b_lsb   = b_reg[0];
  assign b_zero  = ~|b_reg;
  assign product = p_reg;

endmodule
